// File: rtl/led_status_dev.sv
// Registered ALU status-flag to board-LED mapper with live, sticky, sticky-blink
// and saturating event-count display modes.
module led_status_dev #(
  parameter int N_FLAGS   = 4,
  parameter int N_LED     = 8,
  parameter int BLINK_DIV = 25000000,
  parameter int DIV_W     = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_FLAGS-1:0] flag_in,
  input  logic [1:0]         mode,
  input  logic               clr,
  output logic [N_LED-1:0]   LED,
  output logic               any_latched
);

  typedef enum logic [1:0] {
    MODE_LIVE   = 2'b00,
    MODE_STICKY = 2'b01,
    MODE_BLINK  = 2'b10,
    MODE_COUNT  = 2'b11
  } mode_t;

  localparam logic [N_LED-1:0] CNT_MAX  = '1;
  localparam logic [N_LED-1:0] CNT_ONE  = N_LED'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BLINK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  logic [N_FLAGS-1:0] flag_q;
  logic [N_FLAGS-1:0] flag_d;
  logic [N_FLAGS-1:0] sticky;
  logic [N_LED-1:0]   evt_cnt;
  logic [DIV_W-1:0]   div_cnt;
  logic               blink;

  logic [N_FLAGS-1:0] rise;
  logic               evt;
  logic [N_FLAGS-1:0] sticky_next;
  logic [N_LED-1:0]   cnt_base;
  logic [N_LED-1:0]   evt_cnt_next;
  logic               div_wrap;
  logic [DIV_W-1:0]   div_cnt_next;
  logic               blink_next;
  logic [N_LED-1:0]   led_next;
  logic               any_next;
  mode_t              disp_mode;

  assign disp_mode = mode_t'(mode);

  // Tracking state always advances; the mode only selects what is shown.
  always_comb begin
    rise         = flag_q & ~flag_d;
    evt          = |rise;
    sticky_next  = (clr ? '0 : sticky) | flag_q;
    cnt_base     = clr ? '0 : evt_cnt;
    evt_cnt_next = cnt_base;
    if (evt && (cnt_base != CNT_MAX)) begin
      evt_cnt_next = cnt_base + CNT_ONE;
    end
    div_wrap     = (div_cnt == DIV_LAST);
    div_cnt_next = div_wrap ? '0 : (div_cnt + DIV_ONE);
    blink_next   = div_wrap ? ~blink : blink;
    any_next     = |sticky_next;

    led_next = '0;
    case (disp_mode)
      MODE_LIVE: begin
        led_next[N_FLAGS-1:0] = flag_q;
      end
      MODE_STICKY: begin
        led_next[N_FLAGS-1:0] = sticky_next;
        led_next[N_LED-1]     = any_next;
      end
      MODE_BLINK: begin
        // Summary LED stays solid so a latched fault is visible in the dark phase.
        led_next[N_FLAGS-1:0] = sticky_next & {N_FLAGS{blink}};
        led_next[N_LED-1]     = any_next;
      end
      default: begin
        led_next = evt_cnt_next;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_q      <= '0;
      flag_d      <= '0;
      sticky      <= '0;
      evt_cnt     <= '0;
      div_cnt     <= '0;
      blink       <= 1'b1;
      LED         <= '0;
      any_latched <= 1'b0;
    end else begin
      flag_q      <= flag_in;
      flag_d      <= flag_q;
      sticky      <= sticky_next;
      evt_cnt     <= evt_cnt_next;
      div_cnt     <= div_cnt_next;
      blink       <= blink_next;
      LED         <= led_next;
      any_latched <= any_next;
    end
  end

endmodule
